// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control unit for a 32-bit single-bus datapath.
// Fetch runs over T0-T2 and execute over T3-T7. Every strobe is a registered
// decode of the state being entered, so the outputs change only on a rising edge.
//
// Memory waits:
//   mem_ready is sampled at the edge that begins a wait-state cycle.
//   If it is high there, that cycle is the completing cycle: MDRin is raised for
//   a read, and the FSM leaves the state on the following edge.
//   A mem_ready held high from an earlier access therefore completes the next
//   access in its first cycle.
//
// The current state is held in state_q (type state_t). Debug logic can bind to
// it directly.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [OPW-1:0]  ir_opcode,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            Cout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic [ALUW-1:0] alu_op,
  output logic            run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef struct packed {
    logic            pcout;
    logic            zlowout;
    logic            mdrout;
    logic            cout;
    logic            marin;
    logic            pcin;
    logic            mdrin;
    logic            irin;
    logic            yin;
    logic            zin;
    logic            incpc;
    logic            read;
    logic            write;
    logic            gra;
    logic            grb;
    logic            grc;
    logic            rin;
    logic            rout;
    logic            baout;
    logic [ALUW-1:0] alu_op;
    logic            run;
  } ctrl_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
  localparam logic [OPW-1:0] OP_HALT = OPW'(27);

  localparam logic [ALUW-1:0] ALU_ADD = ALUW'(0);
  localparam logic [ALUW-1:0] ALU_SUB = ALUW'(1);
  localparam logic [ALUW-1:0] ALU_AND = ALUW'(2);
  localparam logic [ALUW-1:0] ALU_OR  = ALUW'(3);

  state_t         state_q;
  state_t         state_n;
  ctrl_t          ctrl_q;
  logic           rdy_q;   // mem_ready as sampled at the edge that began this cycle
  logic [OPW-1:0] op_q;    // opcode captured as the FSM leaves T2
  logic [OPW-1:0] op_cur;  // opcode that governs the state being entered

  function automatic logic is_rtype(input logic [OPW-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // ld, ldi and st share the base-address calculation in T3/T4.
  function automatic logic is_mem(input logic [OPW-1:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  endfunction

  function automatic logic is_exec(input logic [OPW-1:0] op);
    return is_rtype(op) || is_mem(op) || (op == OP_ADDI);
  endfunction

  function automatic logic [ALUW-1:0] alu_sel(input logic [OPW-1:0] op);
    logic [ALUW-1:0] a;
    unique case (op)
      OP_SUB:  a = ALU_SUB;
      OP_AND:  a = ALU_AND;
      OP_OR:   a = ALU_OR;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  // Strobe set for state s.
  //   first: s is entered from a different state (not a repeated wait cycle).
  //   ready: mem_ready as seen at the edge that enters s.
  function automatic ctrl_t decode(input state_t s, input logic [OPW-1:0] op,
                                   input logic first, input logic ready);
    ctrl_t c;
    c     = '0;
    c.run = 1'b1;
    unique case (s)
      S_T0: begin
        c.pcout = 1'b1;
        c.marin = 1'b1;
        c.incpc = 1'b1;
        c.zin   = 1'b1;
      end
      S_T1: begin
        c.zlowout = 1'b1;
        c.pcin    = first;
        c.read    = 1'b1;
        c.mdrin   = ready;
      end
      S_T2: begin
        c.mdrout = 1'b1;
        c.irin   = 1'b1;
      end
      S_T3: begin
        c.grb   = 1'b1;
        c.rout  = 1'b1;
        c.yin   = 1'b1;
        c.baout = is_mem(op);
      end
      S_T4: begin
        c.zin = 1'b1;
        if (is_rtype(op)) begin
          c.grc    = 1'b1;
          c.rout   = 1'b1;
          c.alu_op = alu_sel(op);
        end else begin
          c.cout   = 1'b1;
          c.alu_op = ALU_ADD;
        end
      end
      S_T5: begin
        c.zlowout = 1'b1;
        if ((op == OP_LD) || (op == OP_ST)) begin
          c.marin = 1'b1;
        end else begin
          c.gra = 1'b1;
          c.rin = 1'b1;
        end
      end
      S_T6: begin
        if (op == OP_LD) begin
          c.read  = 1'b1;
          c.mdrin = ready;
        end else begin
          c.gra   = 1'b1;
          c.rout  = 1'b1;
          c.mdrin = 1'b1;
        end
      end
      S_T7: begin
        if (op == OP_LD) begin
          c.mdrout = 1'b1;
          c.gra    = 1'b1;
          c.rin    = 1'b1;
        end else begin
          c.write = 1'b1;
        end
      end
      S_HALT: c.run = 1'b0;
      default: ;
    endcase
    return c;
  endfunction

  // In T2 the instruction register has just been loaded, so use the live opcode.
  assign op_cur = (state_q == S_T2) ? ir_opcode : op_q;

  // Next-state selection, including the memory wait loops.
  always_comb begin
    state_n = S_RST;
    unique case (state_q)
      S_RST:  state_n = S_T0;
      S_T0:   state_n = S_T1;
      S_T1:   state_n = rdy_q ? S_T2 : S_T1;
      S_T2: begin
        if (ir_opcode == OP_HALT)      state_n = S_HALT;
        else if (is_exec(ir_opcode))   state_n = S_T3;
        else                           state_n = S_T0;
      end
      S_T3:   state_n = S_T4;
      S_T4:   state_n = S_T5;
      S_T5:   state_n = ((op_q == OP_LD) || (op_q == OP_ST)) ? S_T6 : S_T0;
      S_T6: begin
        if (op_q == OP_LD) state_n = rdy_q ? S_T7 : S_T6;
        else               state_n = S_T7;
      end
      S_T7: begin
        if (op_q == OP_ST) state_n = rdy_q ? S_T0 : S_T7;
        else               state_n = S_T0;
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_RST;
    endcase
  end

  // State, captured opcode, ready sample and registered strobes. clr wins everywhere.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_RST;
      ctrl_q  <= decode(S_RST, '0, 1'b0, 1'b0);
      rdy_q   <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_n;
      ctrl_q  <= decode(state_n, op_cur, state_n != state_q, mem_ready);
      rdy_q   <= mem_ready;
      if (state_q == S_T2) op_q <= ir_opcode;
    end
  end

  assign PCout   = ctrl_q.pcout;
  assign Zlowout = ctrl_q.zlowout;
  assign MDRout  = ctrl_q.mdrout;
  assign Cout    = ctrl_q.cout;
  assign MARin   = ctrl_q.marin;
  assign PCin    = ctrl_q.pcin;
  assign MDRin   = ctrl_q.mdrin;
  assign IRin    = ctrl_q.irin;
  assign Yin     = ctrl_q.yin;
  assign Zin     = ctrl_q.zin;
  assign IncPC   = ctrl_q.incpc;
  assign Read    = ctrl_q.read;
  assign Write   = ctrl_q.write;
  assign Gra     = ctrl_q.gra;
  assign Grb     = ctrl_q.grb;
  assign Grc     = ctrl_q.grc;
  assign Rin     = ctrl_q.rin;
  assign Rout    = ctrl_q.rout;
  assign BAout   = ctrl_q.baout;
  assign alu_op  = ctrl_q.alu_op;
  assign run     = ctrl_q.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. Every cycle the full strobe vector is
// compared with a hand-written expected value.
//
// The mem_ready argument of step() is the value presented at the edge that
// begins the checked cycle.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       clr;
  logic [4:0] ir_opcode;
  logic       mem_ready;
  logic PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC;
  logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run;
  logic [3:0] alu_op;

  control_sequencer #(.OPW(5), .ALUW(4)) dut (
    .clk(clk), .clr(clr), .ir_opcode(ir_opcode), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .alu_op(alu_op), .run(run)
  );

  // clock
  always #5 clk = ~clk;

  // Observed strobe vector, with bit positions matching the B_* constants below.
  logic [23:0] obs;
  assign obs = {PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin,
                IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run};

  localparam logic [23:0] B_RUN     = 24'h000001;
  localparam logic [23:0] B_BAOUT   = 24'h000020;
  localparam logic [23:0] B_ROUT    = 24'h000040;
  localparam logic [23:0] B_RIN     = 24'h000080;
  localparam logic [23:0] B_GRC     = 24'h000100;
  localparam logic [23:0] B_GRB     = 24'h000200;
  localparam logic [23:0] B_GRA     = 24'h000400;
  localparam logic [23:0] B_WRITE   = 24'h000800;
  localparam logic [23:0] B_READ    = 24'h001000;
  localparam logic [23:0] B_INCPC   = 24'h002000;
  localparam logic [23:0] B_ZIN     = 24'h004000;
  localparam logic [23:0] B_YIN     = 24'h008000;
  localparam logic [23:0] B_IRIN    = 24'h010000;
  localparam logic [23:0] B_MDRIN   = 24'h020000;
  localparam logic [23:0] B_PCIN    = 24'h040000;
  localparam logic [23:0] B_MARIN   = 24'h080000;
  localparam logic [23:0] B_COUT    = 24'h100000;
  localparam logic [23:0] B_MDROUT  = 24'h200000;
  localparam logic [23:0] B_ZLOWOUT = 24'h400000;
  localparam logic [23:0] B_PCOUT   = 24'h800000;

  // Expected per-step vectors.
  localparam logic [23:0] E_T0     = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
  localparam logic [23:0] E_T1     = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [23:0] E_T1_W0  = B_ZLOWOUT | B_PCIN | B_READ | B_RUN;
  localparam logic [23:0] E_T1_W   = B_ZLOWOUT | B_READ | B_RUN;
  localparam logic [23:0] E_T1_END = B_ZLOWOUT | B_READ | B_MDRIN | B_RUN;
  localparam logic [23:0] E_T2     = B_MDROUT | B_IRIN | B_RUN;
  localparam logic [23:0] E_T3_R   = B_GRB | B_ROUT | B_YIN | B_RUN;
  localparam logic [23:0] E_T3_M   = B_GRB | B_ROUT | B_BAOUT | B_YIN | B_RUN;
  localparam logic [23:0] E_T4_R   = B_GRC | B_ROUT | B_ZIN | B_RUN;
  localparam logic [23:0] E_T4_C   = B_COUT | B_ZIN | B_RUN;
  localparam logic [23:0] E_T5_W   = B_ZLOWOUT | B_GRA | B_RIN | B_RUN;
  localparam logic [23:0] E_T5_A   = B_ZLOWOUT | B_MARIN | B_RUN;
  localparam logic [23:0] E_LD6_W  = B_READ | B_RUN;
  localparam logic [23:0] E_LD6    = B_READ | B_MDRIN | B_RUN;
  localparam logic [23:0] E_LD7    = B_MDROUT | B_GRA | B_RIN | B_RUN;
  localparam logic [23:0] E_ST6    = B_GRA | B_ROUT | B_MDRIN | B_RUN;
  localparam logic [23:0] E_ST7    = B_WRITE | B_RUN;
  localparam logic [23:0] E_RST    = B_RUN;
  localparam logic [23:0] E_HALT   = 24'h000000;

  int n_vec = 0;
  int n_bad = 0;
  logic [23:0] exp_q[$];

  // Scoreboard check: counts the comparison and reports a mismatch.
  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present mem_ready for the next edge, advance one cycle, then compare.
  task automatic step(input string tag, input logic mr, input logic [23:0] exp);
    mem_ready = mr;
    exp_q.push_back(exp);
    tick();
    check(tag, obs, exp_q.pop_front());
  endtask

  // Fetch after the T0 step has been observed; nwait extra T1 cycles.
  task automatic fetch(input logic [4:0] op, input int nwait);
    ir_opcode = op;
    if (nwait == 0) begin
      step("t1", 1'b1, E_T1);
    end else begin
      step("t1_w0", 1'b0, E_T1_W0);
      for (int i = 1; i < nwait; i++) step("t1_w", 1'b0, E_T1_W);
      step("t1_end", 1'b1, E_T1_END);
    end
    step("t2", 1'b1, E_T2);
  endtask

  // R-type instruction followed by the next T0.
  task automatic rtype(input logic [4:0] op, input logic [3:0] alu);
    logic [23:0] e4;
    e4 = E_T4_R | {19'd0, alu, 1'b0};
    fetch(op, 0);
    step("r_t3", 1'b1, E_T3_R);
    step("r_t4", 1'b1, e4);
    step("r_t5", 1'b1, E_T5_W);
    step("r_t0", 1'b1, E_T0);
  endtask

  initial begin
    clr       = 1'b1;
    mem_ready = 1'b1;
    ir_opcode = 5'b00000;

    // Reset held for two edges.
    repeat (2) tick();
    check("rst", obs, E_RST);
    clr = 1'b0;
    step("rst_t0", 1'b1, E_T0);

    // R-type: add, sub, and, or.
    rtype(5'b00011, 4'd0);
    rtype(5'b00100, 4'd1);
    rtype(5'b00101, 4'd2);
    rtype(5'b00110, 4'd3);

    // addi.
    fetch(5'b01100, 0);
    step("addi_t3", 1'b1, E_T3_R);
    step("addi_t4", 1'b1, E_T4_C);
    step("addi_t5", 1'b1, E_T5_W);
    step("addi_t0", 1'b1, E_T0);

    // ldi.
    fetch(5'b00001, 0);
    step("ldi_t3", 1'b1, E_T3_M);
    step("ldi_t4", 1'b1, E_T4_C);
    step("ldi_t5", 1'b1, E_T5_W);
    step("ldi_t0", 1'b1, E_T0);

    // ld with three wait cycles in T6 (11 cycles T0 to T0).
    fetch(5'b00000, 0);
    step("ld_t3", 1'b1, E_T3_M);
    step("ld_t4", 1'b1, E_T4_C);
    step("ld_t5", 1'b1, E_T5_A);
    for (int i = 0; i < 3; i++) step("ld_t6_w", 1'b0, E_LD6_W);
    step("ld_t6", 1'b1, E_LD6);
    step("ld_t7", 1'b1, E_LD7);
    step("ld_t0", 1'b1, E_T0);

    // ld with a stalled fetch and zero-wait T6.
    fetch(5'b00000, 2);
    step("ld2_t3", 1'b1, E_T3_M);
    step("ld2_t4", 1'b1, E_T4_C);
    step("ld2_t5", 1'b1, E_T5_A);
    step("ld2_t6", 1'b1, E_LD6);
    step("ld2_t7", 1'b1, E_LD7);
    step("ld2_t0", 1'b1, E_T0);

    // st with two wait cycles in T7; mem_ready low into T6 has no effect there.
    fetch(5'b00010, 0);
    step("st_t3", 1'b1, E_T3_M);
    step("st_t4", 1'b1, E_T4_C);
    step("st_t5", 1'b1, E_T5_A);
    step("st_t6", 1'b0, E_ST6);
    step("st_t7_w", 1'b0, E_ST7);
    step("st_t7_w", 1'b0, E_ST7);
    step("st_t7", 1'b1, E_ST7);
    step("st_t0", 1'b1, E_T0);

    // Unlisted opcodes are nops: T0, T1, T2, T0.
    fetch(5'b11111, 0);
    step("nop_t0", 1'b1, E_T0);
    fetch(5'b00111, 0);
    step("nop2_t0", 1'b1, E_T0);

    // halt: absorbing, run low, mem_ready toggling ignored.
    fetch(5'b11011, 0);
    for (int i = 0; i < 20; i++) step("halt", 1'($urandom_range(0, 1)), E_HALT);

    // clr leaves HALT.
    clr = 1'b1;
    step("halt_clr", 1'b1, E_RST);
    clr = 1'b0;
    step("halt_clr_t0", 1'b1, E_T0);

    // clr while stalled in T1.
    ir_opcode = 5'b00011;
    step("stall_t1_w0", 1'b0, E_T1_W0);
    step("stall_t1_w", 1'b0, E_T1_W);
    clr = 1'b1;
    step("stall_clr", 1'b0, E_RST);
    clr = 1'b0;
    step("stall_clr_t0", 1'b1, E_T0);

    // A normal instruction after the aborted fetch.
    rtype(5'b00011, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
